risc_v_32_dmem_bus: RTL and testbench

Data-side responder for the RV32I single-cycle core. Answers the core's data_ce/data_we/data_addr/store-data requests with word RAM plus a small MMIO page. The MMIO page holds a free-running cycle counter, a compare timer with an interrupt flag, and a byte TX FIFO drained over a valid/ready stream. Loads return combinationally within the same cycle, as the single-cycle datapath requires; every state change happens on the rising clock edge.

---
 rtl/risc_v_32_dmem_bus.sv | 193 +++++++++++++++++++
 tb/tb_risc_v_32_dmem_bus.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_v_32_dmem_bus.sv
// risc_v_32_dmem_bus
// Data-side responder for the RV32I single-cycle core: word RAM at
// 0x0000_xxxx plus an MMIO page at 0xFFFF_00xx holding a cycle counter,
// a compare timer with a sticky match flag, and a byte TX FIFO drained
// over a valid/ready stream. Loads are combinational; all state changes
// on the rising edge, with a synchronous active-low reset.
module risc_v_32_dmem_bus #(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        timer_irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    // MMIO word offsets (addr[7:2])
    localparam logic [5:0] OFF_CYCLE = 6'h00;
    localparam logic [5:0] OFF_CMP   = 6'h01;
    localparam logic [5:0] OFF_TSTAT = 6'h02;
    localparam logic [5:0] OFF_TXD   = 6'h03;
    localparam logic [5:0] OFF_TXS   = 6'h04;

    localparam logic [FW-1:0] PTR_ONE  = FW'(1);
    localparam logic [FW:0]   CNT_ONE  = (FW + 1)'(1);
    localparam logic [FW:0]   CNT_FULL = (FW + 1)'(FIFO_DEPTH);

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic          w_sel_ram;
    logic          w_sel_mmio;
    logic [AW-1:0] w_ram_idx;
    logic [5:0]    w_off;
    logic          w_rd;
    logic          w_wr;
    logic          w_unused;

    assign w_sel_ram  = (data_addr_i[31:16] == 16'h0000);
    assign w_sel_mmio = (data_addr_i[31:8] == 24'hFFFF00);
    assign w_ram_idx  = data_addr_i[AW+1:2];
    assign w_off      = data_addr_i[7:2];
    assign w_rd       = data_ce_i & ~data_we_i;
    assign w_wr       = data_ce_i & data_we_i;
    // Byte-lane bits and aliased upper RAM bits do not take part in decode.
    assign w_unused   = ^data_addr_i[15:0];

    logic w_mmio_wr;
    logic w_cmp_we;
    logic w_tstat_clr;
    logic w_push_req;
    logic w_ovf_clr;

    assign w_mmio_wr   = w_wr & w_sel_mmio;
    assign w_cmp_we    = w_mmio_wr & (w_off == OFF_CMP);
    assign w_tstat_clr = w_mmio_wr & (w_off == OFF_TSTAT) & data_i[0];
    assign w_push_req  = w_mmio_wr & (w_off == OFF_TXD);
    assign w_ovf_clr   = w_mmio_wr & (w_off == OFF_TXS) & data_i[2];

    // ---------------------------------------------------------------
    // Word RAM (contents are not reset)
    // ---------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];

    // Full-word store; blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (clrn && w_wr && w_sel_ram) begin
            r_mem[w_ram_idx] <= data_i;
        end
    end

    // ---------------------------------------------------------------
    // Cycle counter and compare timer
    // ---------------------------------------------------------------
    logic [31:0] r_cycle;
    logic [31:0] r_cmp;
    logic        r_match;

    // Free-running counter; match compares the pre-increment value and a
    // set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_cycle <= 32'h0000_0000;
            r_cmp   <= 32'hFFFF_FFFF;
            r_match <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_cmp_we) begin
                r_cmp <= data_i;
            end
            if (r_cycle == r_cmp) begin
                r_match <= 1'b1;
            end else if (w_tstat_clr) begin
                r_match <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------
    logic [7:0]    r_buf [FIFO_DEPTH];
    logic [FW-1:0] r_rd_ptr;
    logic [FW-1:0] r_wr_ptr;
    logic [FW:0]   r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == {(FW + 1){1'b0}});
    assign w_pop     = ~w_empty & tx_ready_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovf_set = w_push_req & w_full & ~w_pop;

    // Circular buffer with pointer/count bookkeeping and sticky overflow.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_rd_ptr <= {FW{1'b0}};
            r_wr_ptr <= {FW{1'b0}};
            r_count  <= {(FW + 1){1'b0}};
            r_ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= data_i[7:0];
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------
    logic [31:0] w_rdata;
    logic [7:0]  w_count8;

    assign w_count8 = 8'(r_count);

    // Combinational load mux; anything that is not a qualified load reads 0.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_rd && w_sel_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_rd && w_sel_mmio) begin
            case (w_off)
                OFF_CYCLE: w_rdata = r_cycle;
                OFF_CMP:   w_rdata = r_cmp;
                OFF_TSTAT: w_rdata = {31'h0000_0000, r_match};
                OFF_TXS:   w_rdata = {16'h0000, w_count8, 5'b00000, r_ovf, w_empty, w_full};
                default:   w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign data_o      = w_rdata;
    assign tx_valid_o  = ~w_empty;
    assign tx_data_o   = r_buf[r_rd_ptr];
    assign timer_irq_o = r_match;

endmodule

// File: tb/tb_risc_v_32_dmem_bus.sv
// Scoreboard bench for risc_v_32_dmem_bus: stimulus pushes expectations,
// a negedge monitor pops and compares them; stream bytes are checked
// against an expected-byte queue whenever a handshake is presented.
module tb_risc_v_32_dmem_bus;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        clrn;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        timer_irq_o;

    risc_v_32_dmem_bus #(.DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .data_ce_i   (data_ce_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    // Scoreboard queues: kind 0 = data_o, 1 = tx_valid_o, 2 = timer_irq_o
    int          q_kind[$];
    logic [31:0] q_exp[$];
    string       q_name[$];
    logic [7:0]  q_tx[$];

    int n_checks = 0;
    int n_errors = 0;
    int rel_base = 0;

    int          m_kind;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;
    logic [7:0]  m_byte;

    // Monitor: compare every pending expectation, and every stream beat.
    always @(negedge clk) begin
        while (q_kind.size() > 0) begin
            m_kind = q_kind.pop_front();
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            case (m_kind)
                0:       m_act = data_o;
                1:       m_act = {31'd0, tx_valid_o};
                default: m_act = {31'd0, timer_irq_o};
            endcase
            n_checks++;
            if (m_act !== m_exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", m_name, m_act, m_exp, tb_cyc);
            end
        end
        if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) begin
            n_checks++;
            if (q_tx.size() == 0) begin
                n_errors++;
                $display("FAIL tx_unexpected: got byte %h expected no beat", tx_data_o);
            end else begin
                m_byte = q_tx.pop_front();
                if (tx_data_o !== m_byte) begin
                    n_errors++;
                    $display("FAIL tx_byte: got %h expected %h", tx_data_o, m_byte);
                end
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
        q_kind.push_back(kind);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_ce_i   = 1'b0;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0000;
        data_i      = 32'h0000_0000;
    endtask

    task automatic acc(input logic we, input logic [31:0] addr, input logic [31:0] d);
        data_ce_i   = 1'b1;
        data_we_i   = we;
        data_addr_i = addr;
        data_i      = d;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        acc(1'b0, addr, 32'h0);
        expect_v(0, exp, name);
        tick();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        acc(1'b1, addr, d);
        expect_v(0, 32'h0, "store_data_o_zero");
        tick();
    endtask

    task automatic release_reset();
        clrn     = 1'b1;
        rel_base = tb_cyc;
    endtask

    // Stimulus
    initial begin
        int c;
        clrn       = 1'b0;
        tx_ready_i = 1'b0;
        idle();
        tick(); tick(); tick();
        release_reset();

        // Reset state and cycle counter
        expect_v(1, 32'd0, "reset_tx_valid");
        expect_v(2, 32'd0, "reset_irq");
        rd(32'hFFFF_0000, 32'd0, "cycle_0");
        rd(32'hFFFF_0000, 32'd1, "cycle_1");
        rd(32'hFFFF_0000, 32'd2, "cycle_2");

        // Timer: CMP=20, written in cycle 3
        wr(32'hFFFF_0004, 32'd20);
        idle();
        while ((tb_cyc - rel_base) < 20) tick();
        expect_v(2, 32'd0, "irq_before_match");
        tick();
        expect_v(2, 32'd1, "irq_after_match");
        wr(32'hFFFF_0008, 32'd1);
        expect_v(2, 32'd0, "irq_after_w1c");
        rd(32'hFFFF_0008, 32'd0, "tstat_after_w1c");
        // Set wins over clear in the same cycle
        c = tb_cyc - rel_base;
        wr(32'hFFFF_0004, 32'(c + 2));
        idle();
        tick();
        wr(32'hFFFF_0008, 32'd1);
        expect_v(2, 32'd1, "irq_set_wins");
        rd(32'hFFFF_0008, 32'd1, "tstat_set_wins");
        wr(32'hFFFF_0008, 32'd1);
        expect_v(2, 32'd0, "irq_cleared_again");
        rd(32'hFFFF_0004, 32'(c + 2), "cmp_readback");

        // RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_load");
        rd(32'h0000_0010 + 32'(4 * DEPTH), 32'hDEAD_BEEF, "ram_alias");
        rd(32'h1234_0000, 32'h0, "unmapped_read");
        wr(32'h1234_0010, 32'h5555_5555);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "unmapped_write_ignored");
        wr(32'h0000_0FFC, 32'h0123_4567);
        rd(32'h0000_FFFC, 32'h0123_4567, "ram_last_word_alias");
        wr(32'h0000_0020, 32'h1111_1111);
        acc(1'b0, 32'h0000_0010, 32'h0);
        data_ce_i = 1'b0;
        expect_v(0, 32'h0, "ce_low_reads_zero");
        tick();

        // FIFO fill with ready low
        tx_ready_i = 1'b0;
        expect_v(1, 32'd0, "tx_valid_empty");
        wr(32'hFFFF_000C, 32'h41);
        expect_v(1, 32'd1, "tx_valid_after_push");
        wr(32'hFFFF_000C, 32'h42);
        wr(32'hFFFF_000C, 32'h43);
        wr(32'hFFFF_000C, 32'h44);
        rd(32'hFFFF_0010, 32'h0000_0401, "txstat_full");
        wr(32'hFFFF_000C, 32'h45);
        rd(32'hFFFF_0010, 32'h0000_0405, "txstat_overflow");
        rd(32'hFFFF_000C, 32'h0, "txdata_reads_zero");
        rd(32'hFFFF_0014, 32'h0, "mmio_other_offset");
        // Drain
        q_tx.push_back(8'h41);
        q_tx.push_back(8'h42);
        q_tx.push_back(8'h43);
        q_tx.push_back(8'h44);
        idle();
        tx_ready_i = 1'b1;
        tick(); tick(); tick(); tick();
        expect_v(1, 32'd0, "tx_valid_after_drain");
        rd(32'hFFFF_0010, 32'h0000_0006, "txstat_empty_ovf");
        wr(32'hFFFF_0010, 32'h4);
        rd(32'hFFFF_0010, 32'h0000_0002, "txstat_ovf_cleared");

        // Simultaneous push and pop while full
        tx_ready_i = 1'b0;
        wr(32'hFFFF_000C, 32'h51);
        wr(32'hFFFF_000C, 32'h52);
        wr(32'hFFFF_000C, 32'h53);
        wr(32'hFFFF_000C, 32'h54);
        q_tx.push_back(8'h51);
        q_tx.push_back(8'h52);
        q_tx.push_back(8'h53);
        q_tx.push_back(8'h54);
        q_tx.push_back(8'h55);
        tx_ready_i = 1'b1;
        wr(32'hFFFF_000C, 32'h55);
        tx_ready_i = 1'b0;
        rd(32'hFFFF_0010, 32'h0000_0401, "txstat_push_pop_full");
        idle();
        tx_ready_i = 1'b1;
        tick(); tick(); tick(); tick();
        expect_v(1, 32'd0, "tx_valid_after_drain2");
        tick();
        tx_ready_i = 1'b0;

        // Reset mid-stream with 2 entries queued; store during reset discarded
        wr(32'hFFFF_000C, 32'h61);
        wr(32'hFFFF_000C, 32'h62);
        expect_v(1, 32'd1, "tx_valid_before_reset");
        clrn = 1'b0;
        acc(1'b1, 32'h0000_0020, 32'hAAAA_5555);
        tick();
        release_reset();
        expect_v(1, 32'd0, "tx_valid_after_reset");
        expect_v(2, 32'd0, "irq_after_reset");
        rd(32'hFFFF_0000, 32'd0, "cycle_after_reset");
        rd(32'hFFFF_0010, 32'h0000_0002, "txstat_after_reset");
        rd(32'hFFFF_0004, 32'hFFFF_FFFF, "cmp_after_reset");
        rd(32'h0000_0020, 32'h1111_1111, "ram_write_blocked_in_reset");
        rd(32'hFFFF_0000, 32'd4, "cycle_4_after_reset");

        idle();
        tick(); tick();
        n_checks++;
        if (q_tx.size() != 0 || q_kind.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drained: got %0d bytes/%0d items left expected 0/0", q_tx.size(), q_kind.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
